// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: applies the power-of-two stages of ShAmt
// one per clock through a single shared one-stage shifter.
module shift_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [15:0] In,
    input  logic [3:0]  ShAmt,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] acc;
    logic [15:0] step_val;
    logic [1:0]  op_cap;
    logic [3:0]  amt_cap;
    logic [1:0]  stage;
    logic        accept;
    logic        hi_zero;
    logic        finish;

    // One stage of size 2^st; Op encoding: 00 ROL, 01 SLL, 10 ROR, 11 SRL.
    function automatic logic [15:0] stage_shift(input logic [15:0] v,
                                                input logic [1:0]  op,
                                                input logic [1:0]  st);
        logic [4:0] k;
        k = 5'd1 << st;
        case (op)
            2'b00:   return (v << k) | (v >> (5'd16 - k));
            2'b01:   return v << k;
            2'b10:   return (v >> k) | (v << (5'd16 - k));
            default: return v >> k;
        endcase
    endfunction

    always_comb begin
        accept    = 1'b0;
        hi_zero   = 1'b0;
        finish    = 1'b0;
        step_val  = acc;
        state_nxt = state;

        accept  = Start && ((state == IDLE) || (state == DONE));
        hi_zero = (amt_cap >> ({1'b0, stage} + 3'd1)) == 4'd0;
        finish  = (state == SHIFT) && ((stage == 2'd3) || (EARLY_EXIT && hi_zero));
        if (amt_cap[stage])
            step_val = stage_shift(acc, op_cap, stage);

        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (finish) state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Out is only written on the SHIFT->DONE transition so it holds between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 16'h0000;
            op_cap  <= 2'b00;
            amt_cap <= 4'h0;
            stage   <= 2'd0;
            Out     <= 16'h0000;
        end else if (accept) begin
            acc     <= In;
            op_cap  <= Op;
            amt_cap <= ShAmt;
            stage   <= 2'd0;
        end else if (state == SHIFT) begin
            acc   <= step_val;
            stage <= stage + 2'd1;
            if (finish)
                Out <= step_val;
        end
    end

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: one fixed-latency instance and one
// EARLY_EXIT instance, expected results queued at accept and checked on Done.
module tb_shift_seq_ctrl;

    typedef struct {
        logic [15:0] out;
        int          lat;
        int          cyc0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] in_val = 16'h0000;
    logic [3:0]  sh_amt = 4'h0;
    logic        busy0, done0, busy1, done1;
    logic [15:0] out0, out1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   accepts0 = 0, dones0 = 0, accepts1 = 0, dones1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    shift_seq_ctrl #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Start(start0), .Op(op), .In(in_val),
        .ShAmt(sh_amt), .Busy(busy0), .Done(done0), .Out(out0)
    );

    shift_seq_ctrl #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(start1), .Op(op), .In(in_val),
        .ShAmt(sh_amt), .Busy(busy1), .Done(done1), .Out(out1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-at-a-time reference, deliberately unlike the staged datapath.
    function automatic logic [15:0] refShift(input logic [1:0] o, input logic [15:0] v,
                                             input logic [3:0] a);
        for (int i = 0; i < int'(a); i++) begin
            case (o)
                2'b00:   v = {v[14:0], v[15]};
                2'b01:   v = {v[14:0], 1'b0};
                2'b10:   v = {v[0], v[15:1]};
                default: v = {1'b0, v[15:1]};
            endcase
        end
        return v;
    endfunction

    function automatic int eeLat(input logic [3:0] a);
        for (int i = 3; i >= 0; i--)
            if (a[i]) return i + 1;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Call at a negedge; returns #1 after the accepting edge.
    task automatic applyStimulus(input bit use0, input bit use1, input logic [1:0] o,
                                 input logic [15:0] v, input logic [3:0] a,
                                 input logic [15:0] exp_out);
        op = o; in_val = v; sh_amt = a;
        start0 = use0; start1 = use1;
        @(posedge clk);
        #1;
        if (use0) begin q0.push_back('{exp_out, 4, cyc}); accepts0++; end
        if (use1) begin q1.push_back('{exp_out, eeLat(a), cyc}); accepts1++; end
        start0 = 1'b0; start1 = 1'b0;
        in_val = 16'($urandom); op = 2'($urandom); sh_amt = 4'($urandom);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            if (q0.size() == 0 && q1.size() == 0) return;
            @(negedge clk);
        end
        checkOutput("wait_timeout", 1, 0);
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done0 || busy0) checkOutput("busy_done_excl0", {31'b0, busy0 & done0}, 0);
            if (done1 || busy1) checkOutput("busy_done_excl1", {31'b0, busy1 & done1}, 0);
            if (done0) begin
                dones0++;
                if (q0.size() == 0) checkOutput("unexpected_done0", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    checkOutput("out0", {16'h0, out0}, {16'h0, e0.out});
                    checkOutput("latency0", cyc - e0.cyc0, e0.lat);
                end
            end
            if (done1) begin
                dones1++;
                if (q1.size() == 0) checkOutput("unexpected_done1", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    checkOutput("out1", {16'h0, out1}, {16'h0, e1.out});
                    checkOutput("latency1", cyc - e1.cyc0, e1.lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  d_op  [0:7];
        logic [15:0] d_in  [0:7];
        logic [3:0]  d_amt [0:7];
        logic [15:0] d_exp [0:7];
        logic [15:0] v;
        logic [15:0] r;
        bit          seen;

        d_op[0] = 2'b10; d_in[0] = 16'h8001; d_amt[0] = 4'd1;  d_exp[0] = 16'hC000;
        d_op[1] = 2'b00; d_in[1] = 16'h1234; d_amt[1] = 4'd8;  d_exp[1] = 16'h3412;
        d_op[2] = 2'b11; d_in[2] = 16'h8000; d_amt[2] = 4'd15; d_exp[2] = 16'h0001;
        d_op[3] = 2'b10; d_in[3] = 16'h00F0; d_amt[3] = 4'd4;  d_exp[3] = 16'h000F;
        for (int i = 4; i < 8; i++) begin
            d_op[i] = 2'(i - 4); d_in[i] = 16'hA5A5; d_amt[i] = 4'd0; d_exp[i] = 16'hA5A5;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy0}, 0);
        checkOutput("reset_done", {31'b0, done0}, 0);
        checkOutput("reset_out0", {16'h0, out0}, 0);
        checkOutput("reset_out1", {16'h0, out1}, 0);
        rst_n = 1'b1;

        $display("[TB] SLL latency and Busy profile");
        @(negedge clk);
        applyStimulus(1, 0, 2'b01, 16'h00F0, 4'd4, 16'h0F00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("sll_busy", {31'b0, busy0}, 1);
            checkOutput("sll_nodone", {31'b0, done0}, 0);
        end
        @(negedge clk);
        checkOutput("sll_done", {31'b0, done0}, 1);
        checkOutput("sll_busy_low", {31'b0, busy0}, 0);
        waitIdle();

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(1, 1, d_op[i], d_in[i], d_amt[i], d_exp[i]);
            waitIdle();
        end

        $display("[TB] Start during SHIFT ignored, back-to-back accept");
        @(negedge clk);
        applyStimulus(1, 0, 2'b00, 16'h1234, 4'd4, 16'h2341);
        @(negedge clk);
        start0 = 1'b1; in_val = 16'hFFFF; op = 2'b01; sh_amt = 4'd1;
        @(posedge clk);
        #1 start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = done0;
        end
        checkOutput("b2b_done_seen", {31'b0, seen}, 1);
        applyStimulus(1, 0, 2'b11, 16'hF000, 4'd4, 16'h0F00);
        @(negedge clk);
        checkOutput("b2b_no_gap_busy", {31'b0, busy0}, 1);
        checkOutput("b2b_out_hold", {16'h0, out0}, 32'h2341);
        waitIdle();

        $display("[TB] reset mid-SHIFT");
        @(negedge clk);
        applyStimulus(1, 1, 2'b01, 16'hFFFF, 4'd8, 16'hFF00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy0", {31'b0, busy0}, 0);
        checkOutput("rst_done0", {31'b0, done0}, 0);
        checkOutput("rst_out0", {16'h0, out0}, 0);
        checkOutput("rst_busy1", {31'b0, busy1}, 0);
        checkOutput("rst_out1", {16'h0, out1}, 0);
        q0.delete(); q1.delete();
        accepts0--; accepts1--;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 1, 2'b10, 16'h00F0, 4'd4, 16'h000F);
        waitIdle();

        $display("[TB] sweep of Op x ShAmt");
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 16; a++) begin
                v = 16'($urandom);
                r = refShift(2'(o), v, 4'(a));
                @(negedge clk);
                applyStimulus(1, 1, 2'(o), v, 4'(a), r);
                waitIdle();
                @(negedge clk);
                checkOutput("out_hold", {16'h0, out0}, {16'h0, r});
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("done_count0", dones0, accepts0);
        checkOutput("done_count1", dones1, accepts1);
        checkOutput("queue_empty", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
